// File: rtl/hs32_sram16_if.sv
// hs32_sram16_if: CPU-side request/response bus for the 32-bit to 16-bit SRAM bridge.
interface hs32_sram16_if;
   logic [31:0] addr;
   logic        rw;
   logic [31:0] din;
   logic [31:0] dout;
   logic        valid;
   logic        done;
   modport master (output addr, rw, din, valid, input dout, done);
   modport slave  (input addr, rw, din, valid, output dout, done);
endinterface

// File: rtl/hs32_sram16.sv
// hs32_sram16: bridges 32-bit CPU accesses to an asynchronous 16-bit SRAM as two halfword phases.
module hs32_sram16 #(
   parameter int WAIT = 1
) (
   input  logic                clk,
   input  logic                reset,
   hs32_sram16_if.slave        bus,
   output logic [15:0]         sram_a,
   output logic [15:0]         sram_dq_o,
   input  logic [15:0]         sram_dq_i,
   output logic                sram_dq_oe,
   output logic                sram_ce_n,
   output logic                sram_oe_n,
   output logic                sram_we_n
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t state, state_nx;
   logic [3:0]  cnt;
   logic [14:0] a_q;
   logic        rw_q;
   logic [31:0] din_q;
   logic [31:0] dout_q;
   logic        phase, last, first;
   assign phase = state == LO || state == HI;
   assign last = cnt == 4'd0;
   assign first = cnt == 4'(WAIT);
   assign bus.dout = dout_q;
   always_comb begin
      state_nx = state;
      bus.done = 1'b0;
      sram_a = '0;
      sram_dq_o = '0;
      sram_dq_oe = 1'b0;
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      case (state)
         IDLE: state_nx = bus.valid ? LO : IDLE;
         LO:   state_nx = last ? HI : LO;
         HI:   state_nx = last ? DONE : HI;
         DONE: begin
            state_nx = IDLE;
            bus.done = 1'b1;
         end
      endcase
      if (phase) begin
         sram_ce_n = 1'b0;
         sram_a = {a_q, state == HI};
         sram_oe_n = rw_q;
         sram_dq_oe = rw_q;
         sram_dq_o = rw_q ? (state == HI ? din_q[31:16] : din_q[15:0]) : '0;
         // first phase cycle holds we_n high for address setup unless there is only one cycle
         sram_we_n = !(rw_q && (WAIT == 0 || !first));
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         a_q <= '0;
         rw_q <= 1'b0;
         din_q <= '0;
         dout_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.valid) begin
            a_q <= bus.addr[16:2];
            rw_q <= bus.rw;
            din_q <= bus.din;
         end
         cnt <= (state_nx != state && (state_nx == LO || state_nx == HI)) ? 4'(WAIT) :
                (phase && !last) ? cnt - 4'd1 : 4'd0;
         if (phase && last && !rw_q) begin
            if (state == LO) dout_q[15:0] <= sram_dq_i;
            else dout_q[31:16] <= sram_dq_i;
         end
      end
   end
endmodule
